// File: rtl/cva5_types.sv
// Shared store-queue types: entry payload, address hash, instruction id
// and slot index, plus the load/store address hash helper.
package cva5_types;

  localparam int LOG2_SQ_DEPTH = 2;
  localparam int ID_W = 6;

  typedef logic [LOG2_SQ_DEPTH-1:0] sq_index_t;
  typedef logic [3:0] addr_hash_t;
  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic [1:0]  offset;
    logic [3:0]  be;
    logic [1:0]  cache_op;
    logic [31:0] data;
    logic        fp;
    logic        double;
    logic [31:0] fp_data;
  } sq_entry_t;

  function automatic addr_hash_t addr_hash(
    input logic [31:0] addr
  );
    return addr[5:2];
  endfunction

endpackage

// File: rtl/sq_collision_detect.sv
// Youngest-match priority pick over a circular store buffer.
// Ports: match (per slot), tail_idx in; collision, collision_index out.
module sq_collision_detect #(
  parameter int DEPTH = 4,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [IW-1:0]    tail_idx,
  output logic             collision,
  output logic [IW-1:0]    collision_index
);

  logic [IW-1:0] idx;

  // Walk from oldest (tail - DEPTH) to youngest (tail - 1);
  // a later hit overrides, so the youngest match wins.
  always_comb begin
    collision = |match;
    collision_index = '0;
    idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      idx = tail_idx - IW'(k);
      if (match[idx])
        collision_index = idx;
    end
  end

endmodule

// File: rtl/store_queue.sv
// Circular store queue: commit on retire, drain in order, flush drops
// uncommitted stores. Ports: push_*, retire_*, flush, out_*, lookup.
module store_queue
  import cva5_types::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  sq_entry_t         push_entry,
  input  logic [31:0]       push_addr,
  input  id_t               push_id,
  input  logic              retire_valid,
  input  id_t               retire_id,
  input  logic              flush,
  output logic              out_valid,
  output sq_entry_t         out_entry,
  output logic [31:0]       out_addr,
  input  logic              out_ready,
  input  addr_hash_t        lookup_hash,
  output logic              collision,
  output logic [LOG2_SQ_DEPTH-1:0] collision_index,
  output logic              full,
  output logic              empty
);

  localparam int IW = $clog2(DEPTH);
  typedef logic [IW:0] ptr_t;

  ptr_t head;
  ptr_t tail;
  ptr_t head_n;
  ptr_t tail_n;
  ptr_t commit_cnt;

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] committed;
  logic [DEPTH-1:0] valid_n;
  logic [DEPTH-1:0] comm_n;
  logic [DEPTH-1:0] retire_hit;
  logic [DEPTH-1:0] commit_next;
  logic [DEPTH-1:0] match;

  sq_entry_t   entry_q [DEPTH];
  logic [31:0] addr_q  [DEPTH];
  id_t         id_q    [DEPTH];
  addr_hash_t  hash_q  [DEPTH];

  logic [IW-1:0] head_idx;
  logic [IW-1:0] tail_idx;
  logic [IW-1:0] coll_idx;
  logic          push_fire;
  logic          pop_fire;

  assign head_idx = head[IW-1:0];
  assign tail_idx = tail[IW-1:0];

  assign empty = (head == tail);
  assign full  = (head_idx == tail_idx) &&
                 (head[IW] != tail[IW]);

  assign push_fire = push_valid & ~full & ~flush;
  assign out_valid = valid[head_idx] & committed[head_idx];
  assign pop_fire  = out_valid & out_ready;

  assign out_entry = entry_q[head_idx];
  assign out_addr  = addr_q[head_idx];

  always_comb begin
    retire_hit = '0;
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      retire_hit[i] = retire_valid & valid[i] &
                      ~committed[i] &
                      (id_q[i] == retire_id);
      match[i] = valid[i] & (hash_q[i] == lookup_hash);
    end
  end

  // Retire is folded in before flush so a same-cycle
  // retire keeps its store alive.
  assign commit_next = committed | retire_hit;

  // Committed entries are contiguous from head, so the
  // popcount gives the new tail offset on flush.
  always_comb begin
    commit_cnt = '0;
    for (int i = 0; i < DEPTH; i++)
      commit_cnt = commit_cnt +
                   ptr_t'(valid[i] & commit_next[i]);
  end

  always_comb begin
    valid_n = valid;
    comm_n  = commit_next & valid;
    if (flush)
      valid_n = valid & commit_next;
    if (pop_fire) begin
      valid_n[head_idx] = 1'b0;
      comm_n[head_idx]  = 1'b0;
    end
    if (push_fire) begin
      valid_n[tail_idx] = 1'b1;
      comm_n[tail_idx]  = 1'b0;
    end
  end

  always_comb begin
    head_n = pop_fire ? head + ptr_t'(1) : head;
    if (flush)
      tail_n = head + commit_cnt;
    else if (push_fire)
      tail_n = tail + ptr_t'(1);
    else
      tail_n = tail;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      valid     <= '0;
      committed <= '0;
    end else begin
      head      <= head_n;
      tail      <= tail_n;
      valid     <= valid_n;
      committed <= comm_n;
    end
  end

  // Payload and tag storage; only read under a valid bit.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      entry_q[tail_idx] <= push_entry;
      addr_q[tail_idx]  <= push_addr;
      id_q[tail_idx]    <= push_id;
      hash_q[tail_idx]  <= addr_hash(push_addr);
    end
  end

  sq_collision_detect #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_coll (
    .match           (match),
    .tail_idx        (tail_idx),
    .collision       (collision),
    .collision_index (coll_idx)
  );

  assign collision_index = sq_index_t'(coll_idx);

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue with a scoreboard of committed
// stores popped and checked by an independent monitor.
module tb_store_queue;
  import cva5_types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        push_valid;
  sq_entry_t   push_entry;
  logic [31:0] push_addr;
  id_t         push_id;
  logic        retire_valid;
  id_t         retire_id;
  logic        flush;
  logic        out_valid;
  sq_entry_t   out_entry;
  logic [31:0] out_addr;
  logic        out_ready;
  addr_hash_t  lookup_hash;
  logic        collision;
  logic [LOG2_SQ_DEPTH-1:0] collision_index;
  logic        full;
  logic        empty;

  int errors = 0;
  int checks = 0;
  logic [31:0] sb[$];

  store_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .push_valid      (push_valid),
    .push_entry      (push_entry),
    .push_addr       (push_addr),
    .push_id         (push_id),
    .retire_valid    (retire_valid),
    .retire_id       (retire_id),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_entry       (out_entry),
    .out_addr        (out_addr),
    .out_ready       (out_ready),
    .lookup_hash     (lookup_hash),
    .collision       (collision),
    .collision_index (collision_index),
    .full            (full),
    .empty           (empty)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_data(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic sq_entry_t mk_entry(input logic [31:0] a);
    sq_entry_t e;
    e.offset   = a[1:0];
    e.be       = 4'hF;
    e.cache_op = 2'd0;
    e.data     = mk_data(a);
    e.fp       = 1'b0;
    e.double   = 1'b0;
    e.fp_data  = ~a;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle();
    push_valid   = 1'b0;
    push_addr    = '0;
    push_id      = '0;
    push_entry   = mk_entry(32'h0);
    retire_valid = 1'b0;
    retire_id    = '0;
    flush        = 1'b0;
    out_ready    = 1'b0;
    lookup_hash  = '0;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    idle();
    sb.delete();
    next();
    rst_n = 1'b1;
  endtask

  task automatic set_push(input id_t id, input logic [31:0] a);
    push_valid = 1'b1;
    push_id    = id;
    push_addr  = a;
    push_entry = mk_entry(a);
  endtask

  task automatic push_one(input id_t id, input logic [31:0] a);
    set_push(id, a);
    next();
    push_valid = 1'b0;
  endtask

  task automatic retire_one(input id_t id, input logic [31:0] a);
    retire_valid = 1'b1;
    retire_id    = id;
    sb.push_back(a);
    next();
    retire_valid = 1'b0;
  endtask

  // Monitor: every accepted head is checked against the
  // oldest outstanding committed store.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got addr %0h expected none",
                 out_addr);
      end else begin
        logic [31:0] e;
        e = sb.pop_front();
        chk("pop_addr", out_addr, e);
        chk("pop_data", out_entry.data, mk_data(e));
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #12;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_collision", collision, 0);
    chk("rst_coll_idx", collision_index, 0);
    next();
    rst_n = 1'b1;

    // Fill to full; fifth push is dropped.
    for (int i = 1; i <= 4; i++)
      push_one(id_t'(i), 32'h100 * i + 32'(4 * i));
    mid();
    chk("fill_full", full, 1);
    chk("fill_empty", empty, 0);
    next();
    set_push(id_t'(5), 32'h500);
    mid();
    chk("fifth_full", full, 1);
    next();
    push_valid = 1'b0;
    mid();
    chk("fifth_still_full", full, 1);
    next();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++)
      retire_one(id_t'(i), 32'h100 * i + 32'(4 * i));
    next();
    mid();
    chk("drain_empty", empty, 1);
    chk("drain_out_valid", out_valid, 0);
    next();

    // Retire-to-out_valid latency and hold while stalled.
    reset_dut();
    push_one(id_t'(5), 32'h204);
    retire_valid = 1'b1;
    retire_id    = id_t'(5);
    sb.push_back(32'h204);
    mid();
    chk("lat_not_yet", out_valid, 0);
    next();
    retire_valid = 1'b0;
    mid();
    chk("lat_valid", out_valid, 1);
    chk("hold_addr0", out_addr, 32'h204);
    next();
    mid();
    chk("hold_valid", out_valid, 1);
    chk("hold_addr1", out_addr, 32'h204);
    next();
    out_ready = 1'b1;
    next();
    out_ready = 1'b0;
    mid();
    chk("pop_empty", empty, 1);
    next();

    // Youngest collision; same-cycle push excluded.
    reset_dut();
    push_one(id_t'(1), 32'h10);
    push_one(id_t'(2), 32'h50);
    set_push(id_t'(3), 32'h90);
    lookup_hash = 4'd4;
    mid();
    chk("coll_hit", collision, 1);
    chk("coll_idx_young", collision_index, 1);
    next();
    push_valid = 1'b0;
    mid();
    chk("coll_idx_after_push", collision_index, 2);
    lookup_hash = 4'd5;
    #1;
    chk("coll_miss", collision, 0);
    next();

    // Retire and flush together keep only id 1.
    reset_dut();
    push_one(id_t'(1), 32'h04);
    push_one(id_t'(2), 32'h08);
    push_one(id_t'(3), 32'h0C);
    flush = 1'b1;
    retire_one(id_t'(1), 32'h04);
    flush = 1'b0;
    mid();
    chk("flush_empty", empty, 0);
    chk("flush_full", full, 0);
    chk("flush_keep_valid", out_valid, 1);
    lookup_hash = 4'd2;
    #1;
    chk("flush_drop_coll", collision, 0);
    next();
    push_one(id_t'(9), 32'h3C);
    lookup_hash = 4'hF;
    mid();
    chk("flush_next_coll", collision, 1);
    chk("flush_next_slot", collision_index, 1);
    next();
    out_ready = 1'b1;
    next();
    retire_one(id_t'(9), 32'h3C);
    next();
    mid();
    chk("flush_drain_empty", empty, 1);
    next();
    out_ready = 1'b0;

    // Pop plus push while full across the index wrap.
    reset_dut();
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++)
      push_one(id_t'(i), 32'h200 + 32'(4 * i));
    for (int i = 1; i <= 3; i++)
      retire_one(id_t'(i), 32'h200 + 32'(4 * i));
    next();
    out_ready = 1'b0;
    for (int i = 4; i <= 7; i++)
      push_one(id_t'(i), 32'(4 * (i - 3)));
    mid();
    chk("wrap_full", full, 1);
    next();
    retire_one(id_t'(4), 32'h04);
    out_ready = 1'b1;
    set_push(id_t'(8), 32'h20);
    mid();
    chk("wrap_full_pop_cycle", full, 1);
    next();
    push_valid = 1'b0;
    out_ready  = 1'b0;
    lookup_hash = 4'd8;
    mid();
    chk("wrap_not_full", full, 0);
    chk("wrap_not_empty", empty, 0);
    chk("wrap_drop_coll", collision, 0);
    next();
    out_ready = 1'b1;
    for (int i = 5; i <= 7; i++)
      retire_one(id_t'(i), 32'(4 * (i - 3)));
    next();
    mid();
    chk("wrap_drain_empty", empty, 1);
    chk("wrap_sb_left", sb.size(), 0);
    next();
    out_ready = 1'b0;
    push_one(id_t'(9), 32'h24);
    lookup_hash = 4'd9;
    mid();
    chk("wrap_tail_slot", collision_index, 3);
    next();

    // Asynchronous reset drops committed stores at once.
    reset_dut();
    push_one(id_t'(1), 32'h104);
    push_one(id_t'(2), 32'h108);
    retire_one(id_t'(1), 32'h104);
    retire_one(id_t'(2), 32'h108);
    mid();
    chk("pre_rst_valid", out_valid, 1);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_empty", empty, 1);
    chk("async_full", full, 0);
    next();
    rst_n = 1'b1;
    next();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of store entries; it must be a power of two and at least 2.
REQ-002 The block SHALL have port clk, input, width 1: the single clock; all state is rising-edge.
REQ-003 The block SHALL have port rst_n, input, width 1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port push_valid, input, width 1: a new store is offered.
REQ-005 The block SHALL have port push_entry, input, sq_entry_t: store payload (offset, be, cache_op, data, fp, double, fp_data).
REQ-006 The block SHALL have port push_addr, input, width 32: full store address.
REQ-007 The block SHALL have port push_id, input, id_t: instruction id of the store.
REQ-008 The block SHALL have port retire_valid, input, width 1: the retire port fired this cycle.
REQ-009 The block SHALL have port retire_id, input, id_t: id of the retired instruction.
REQ-010 The block SHALL have port flush, input, width 1: discard all uncommitted stores.
REQ-011 The block SHALL have port out_valid, output, width 1: head store is committed and available.
REQ-012 The block SHALL have port out_entry, output, sq_entry_t: head payload.
REQ-013 The block SHALL have port out_addr, output, width 32: head address.
REQ-014 The block SHALL have port out_ready, input, width 1: the consumer accepts the head.
REQ-015 The block SHALL have port lookup_hash, input, addr_hash_t: hash of an issuing load.
REQ-016 The block SHALL have port collision, output, width 1: the load hash matches a valid entry.
REQ-017 The block SHALL have port collision_index, output, width LOG2_SQ_DEPTH: slot of the youngest match.
REQ-018 The block SHALL have port full, output, width 1: no free slot.
REQ-019 The block SHALL have port empty, output, width 1: no valid entries.

Function
REQ-020 Storage SHALL be a circular buffer indexed by head and tail pointers of log2(DEPTH)+1 bits, using the extra bit to tell full from empty on wrap-around.
REQ-021 A push SHALL be accepted when push_valid=1, full=0 and flush=0; it writes the slot at tail with valid=1, committed=0 and hash=push_addr[5:2], and tail advances by 1.
REQ-022 full SHALL be computed from registered state only; a push while full is dropped even if a pop occurs in the same cycle.
REQ-023 A retire SHALL set committed=1 on every valid, uncommitted entry whose id equals retire_id when retire_valid=1; the bit is visible the next cycle.
REQ-024 out_valid SHALL equal the head entry's valid AND committed bits; the minimum latency from a retire to out_valid is 1 cycle.
REQ-025 A pop SHALL occur when out_valid=1 and out_ready=1: the head slot is cleared and head advances by 1; out_entry and out_addr hold steady while out_valid=1 and out_ready=0.
REQ-026 Push and pop in the same cycle SHALL both take effect; the count is unchanged.
REQ-027 collision SHALL be combinational in the same cycle: the OR over valid entries of (hash == lookup_hash).
REQ-028 collision_index SHALL be the matching slot closest to tail (the youngest match); a push in the same cycle is excluded from the match, and a pop in the same cycle is still included.
REQ-029 On flush, at the next edge, tail SHALL be set to head + (number of committed entries) and every uncommitted entry is invalidated.
REQ-030 During a flush cycle, a pop still completes and a push is ignored.
REQ-031 Committed entries SHALL be contiguous from head, which holds because commits arrive in program order.
REQ-032 A retire and a flush in the same cycle SHALL apply the retire first, so the matching entry survives the flush.
REQ-033 empty SHALL equal (head == tail), and full SHALL equal (pointer indices equal and wrap bits different).

Reset
REQ-034 While rst_n=0, head, tail and all valid and committed bits SHALL be 0, with out_valid=0, collision=0, collision_index=0, full=0 and empty=1.
REQ-035 Payload RAM SHALL need no reset.
REQ-036 Reset asserted mid-operation SHALL discard all entries, including committed ones, at once.

Structure
REQ-037 sq_entry_t, addr_hash_t, id_t and LOG2_SQ_DEPTH SHALL come from cva5_types; a new sq_index_t (logic[LOG2_SQ_DEPTH-1:0]) SHALL be added there.
REQ-038 The youngest-match priority logic SHALL be one sub-module, sq_collision_detect, taking a per-slot match vector and the tail index and returning collision and collision_index.

Verification
REQ-039 Reset then push 4 stores (ids 1-4, DEPTH=4) -> full=1 and empty=0; a 5th push is dropped and the count stays 4.
REQ-040 Push id 5, then retire id 5 in the next cycle -> out_valid=1 one cycle later; with out_ready=1, empty=1 the following cycle.
REQ-041 Push addrs 0x10 and 0x50 (both hash 4); lookup_hash=4 -> collision=1 and collision_index=1 (the younger slot).
REQ-042 Push ids 1-3, retire id 1, flush -> the count becomes 1 and tail=head+1; the next push lands in slot 1.
REQ-043 Pop and push in the same cycle across the index wrap (head=3, tail=3 with wrap bits different) -> full stays 1 and the pointers wrap correctly.
REQ-044 Drop rst_n mid-stream with 2 committed entries -> out_valid=0 and empty=1 immediately, asynchronously.
